// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 multiplier among NUM_REQ requesters.
// Latency: transfer in cycle T -> issue in T+1 -> one-hot response pulse in T+2+MUL_LATENCY.
// Backpressure: one combinational grant per cycle; responses cannot be stalled. Optional FPMUL_ARB_CHECK_EN builds the err checker.
module fp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 4,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    output logic                    mul_in_valid,
    input  logic [31:0]             mul_result,
    input  logic                    mul_valid,
    output logic                    err
);

    localparam int LAST = MUL_LATENCY;

    logic [ID_W-1:0]              ptr;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_W-1:0]              gnt_id;
    logic                         found;
    logic                         xfer;
    logic [31:0]                  sel_a;
    logic [31:0]                  sel_b;
    logic [LAST:0]                tag_vld;
    logic [LAST:0][ID_W-1:0]      tag_id;

    // Position k steps after the pointer, wrapped into 0..NUM_REQ-1.
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s;
    endfunction

    // First requesting slot at or after ptr wins; everything else stays low.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_idx(int'(ptr), k)]) begin
                found                         = 1'b1;
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                gnt_id                        = ID_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

    // Grants are suppressed while in reset so nothing can transfer then.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = found & ~rst;
    assign sel_a     = req_a[32*gnt_id +: 32];
    assign sel_b     = req_b[32*gnt_id +: 32];

    // Pointer moves past the winner only when a transfer happens.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end

    // Issue stage: register the winning operands and the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a        <= '0;
            mul_b        <= '0;
            mul_in_valid <= 1'b0;
        end else begin
            mul_in_valid <= xfer;
            if (xfer) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
        end
    end

    // Tag pipe mirrors the multiplier; the last stage lines up with mul_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[LAST-1:0], xfer};
            tag_id  <= {tag_id[LAST-1:0], gnt_id};
        end
    end

    // Route the result back to its owner as a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (tag_vld[LAST]) begin
                resp_valid <= NUM_REQ'(1) << tag_id[LAST];
                resp_data  <= mul_result;
            end
        end
    end

`ifdef FPMUL_ARB_CHECK_EN
    localparam int CW = $clog2(MUL_LATENCY + 2) + 1;
    logic [CW-1:0] blank_cnt;
    logic          armed;

    assign armed = (blank_cnt == CW'(MUL_LATENCY + 1));

    // Hold off checking until stale multiplier outputs from before reset have drained.
    always_ff @(posedge clk) begin
        if (rst)
            blank_cnt <= '0;
        else if (!armed)
            blank_cnt <= blank_cnt + 1'b1;
    end

    // Sticky flag: multiplier strobe disagrees with the tag pipe.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (armed && (mul_valid != tag_vld[LAST]))
            err <= 1'b1;
    end
`else
    logic unused_mul_valid;
    assign unused_mul_valid = mul_valid;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural fixed-latency multiplier.
// Latency: expects issue at T+1 and response at T+6 for MUL_LATENCY=4.
// Backpressure: requesters drop valid only after their transfer; responses are logged at every negedge.
module tb_fp_mul_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_data;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic              mul_in_valid;
    logic [31:0]       mul_result;
    logic              mul_valid;
    logic              err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic extra_delay = 1'b0;

    logic [L:0]  mv_pipe = '0;
    logic [31:0] md_pipe [0:L];

    logic [N-1:0] rv_q [$];
    logic [31:0]  rd_q [$];
    int           rc_q [$];

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
        .mul_result(mul_result), .mul_valid(mul_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Hand-computed squares of the operands used in this bench.
    function automatic logic [31:0] sq(input logic [31:0] a, input logic [31:0] b);
        if (a != b) return 32'hBAD0BAD0;
        case (a)
            32'h3F800000: return 32'h3F800000;
            32'h40000000: return 32'h40800000;
            32'h40400000: return 32'h41100000;
            32'h40200000: return 32'h40C80000;
            32'hC1200000: return 32'h42C80000;
            default:      return 32'hBAD0BAD0;
        endcase
    endfunction

    // Behavioural multiplier, optionally one cycle late on both strobe and data.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mv_pipe <= {mv_pipe[L-1:0], mul_in_valid};
        md_pipe[0] <= sq(mul_a, mul_b);
        for (int j = 1; j <= L; j++) md_pipe[j] <= md_pipe[j-1];
    end
    assign mul_valid  = extra_delay ? mv_pipe[L] : mv_pipe[L-1];
    assign mul_result = extra_delay ? md_pipe[L] : md_pipe[L-1];

    // Response logger.
    always @(negedge clk) begin
        if (|resp_valid) begin
            rv_q.push_back(resp_valid);
            rd_q.push_back(resp_data);
            rc_q.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_log();
        rv_q.delete();
        rd_q.delete();
        rc_q.delete();
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // One isolated operation with exact-cycle checks of issue and response.
    task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        step();
        set_ops(id, a, b);
        req_valid = N'(1) << id;
        smp();
        chk("single_grant", 32'(req_ready), 32'(N'(1) << id));
        step();
        req_valid = '0;
        smp();
        chk("issue_valid", 32'(mul_in_valid), 32'd1);
        chk("issue_a", mul_a, a);
        chk("issue_b", mul_b, b);
        repeat (4) step();
        smp();
        chk("resp_early", 32'(resp_valid), 32'd0);
        step();
        smp();
        chk("resp_valid", 32'(resp_valid), 32'(N'(1) << id));
        chk("resp_data", resp_data, exp);
        step();
        smp();
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int c1, c3, bad;
        vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[1] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
        vecs[2] = '{3, 32'h40400000, 32'h40400000, 32'h41100000};
        vecs[3] = '{2, 32'h40200000, 32'h40200000, 32'h40C80000};
        vecs[4] = '{3, 32'hC1200000, 32'hC1200000, 32'h42C80000};

        // Reset with all requests raised: no grant may appear.
        req_valid = '1;
        repeat (2) step();
        smp();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_mul_in_valid", 32'(mul_in_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        step();
        req_valid = '0;
        rst = 1'b0;

        // Table of isolated operations; ends on id 3 so the pointer is back at 0.
        for (int i = 0; i < 5; i++)
            run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

        // All four together: grants 0..3 back to back, responses in order.
        clear_log();
        step();
        set_ops(0, 32'h40000000, 32'h40000000);
        set_ops(1, 32'h40400000, 32'h40400000);
        set_ops(2, 32'h40200000, 32'h40200000);
        set_ops(3, 32'hC1200000, 32'hC1200000);
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("four_grant", 32'(req_ready), 32'(N'(1) << k));
            step();
            req_valid[k] = 1'b0;
        end
        repeat (10) step();
        chk("four_resp_count", rv_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < rv_q.size(); k++) begin
            chk("four_resp_valid", 32'(rv_q[k]), 32'(N'(1) << k));
            chk("four_resp_data", rd_q[k], sq(req_a[32*k +: 32], req_b[32*k +: 32]));
            chk("four_resp_cycle", rc_q[k] - rc_q[0], k);
        end

        // Fairness: 1 and 3 held for 8 cycles alternate.
        clear_log();
        step();
        set_ops(1, 32'h40000000, 32'h40000000);
        set_ops(3, 32'h40400000, 32'h40400000);
        req_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("fair_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            step();
        end
        req_valid = '0;
        repeat (10) step();
        c1 = 0; c3 = 0; bad = 0;
        foreach (rv_q[k]) begin
            if (rv_q[k] == 4'b0010) begin
                c1++;
                if (rd_q[k] != 32'h40800000) bad++;
            end else if (rv_q[k] == 4'b1000) begin
                c3++;
                if (rd_q[k] != 32'h41100000) bad++;
            end else begin
                bad++;
            end
        end
        chk("fair_count_1", c1, 32'd4);
        chk("fair_count_3", c3, 32'd4);
        chk("fair_bad_resp", bad, 32'd0);

        // Pointer wrap: after a grant to 3, requester 0 beats requester 2.
        step();
        set_ops(3, 32'h40400000, 32'h40400000);
        req_valid = 4'b1000;
        smp();
        chk("wrap_grant3", 32'(req_ready), 32'h8);
        step();
        set_ops(0, 32'h3F800000, 32'h3F800000);
        set_ops(2, 32'h40200000, 32'h40200000);
        req_valid = 4'b0101;
        smp();
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0100;
        smp();
        chk("wrap_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (10) step();

        // Reset mid-flight: three ops issued, then a one-cycle reset drops them.
        step();
        set_ops(0, 32'h3F800000, 32'h3F800000);
        set_ops(1, 32'h40000000, 32'h40000000);
        set_ops(2, 32'h40400000, 32'h40400000);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("mid_grant", 32'(req_ready), 32'(N'(1) << k));
            step();
            req_valid[k] = 1'b0;
        end
        step();
        clear_log();
        rst = 1'b1;
        req_valid = 4'b0010;
        smp();
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        req_valid = '0;
        smp();
        chk("mid_rst_issue", 32'(mul_in_valid), 32'd0);
        chk("mid_rst_data", resp_data, 32'd0);
        repeat (10) step();
        chk("mid_dropped", rv_q.size(), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        run_single(1, 32'h40000000, 32'h40000000, 32'h40800000);

`ifdef FPMUL_ARB_CHECK_EN
        // Late multiplier strobe must raise the sticky error flag.
        extra_delay = 1'b1;
        step();
        set_ops(2, 32'h40200000, 32'h40200000);
        req_valid = 4'b0100;
        smp();
        chk("chk_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (L) step();
        smp();
        chk("chk_err_before", 32'(err), 32'd0);
        step();
        smp();
        chk("chk_err_set", 32'(err), 32'd1);
        repeat (6) step();
        smp();
        chk("chk_err_sticky", 32'(err), 32'd1);
        extra_delay = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        smp();
        chk("chk_err_cleared", 32'(err), 32'd0);
`endif

        repeat (12) step();
        smp();
        chk("final_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one fixed-latency IEEE-754 single-precision multiplier (the `a`/`b`/`result`/`valid` unit) among NUM_REQ requesters.
- Arbitration is round-robin, with a valid/ready handshake per requester.
- Issues at most one operation per cycle into the multiplier pipeline.
- Tracks each in-flight requester ID in a tag shift register and routes each result back to its owner as a one-cycle response pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 4, cycles from mul_in_valid high to matching mul_valid high (>=1).
- ID_W, 2, requester-ID width, clog2(NUM_REQ); must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  32*NUM_REQ  operand A, flat; requester i at [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, flat, same layout.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- resp_valid  out  NUM_REQ  one-hot registered result pulse.
- resp_data  out  32  result word; valid when any resp_valid bit is high.
- mul_a  out  32  multiplier operand A, registered.
- mul_b  out  32  multiplier operand B, registered.
- mul_in_valid  out  1  multiplier issue strobe, registered.
- mul_result  in  32  multiplier result.
- mul_valid  in  1  multiplier result strobe.
- err  out  1  sticky tag/valid mismatch flag (see Optional Feature).

Behaviour:
- Reset: req_ready=0, resp_valid=0, resp_data=0, mul_a=0, mul_b=0, mul_in_valid=0, err=0.
  - Round-robin pointer resets to 0.
  - Tag pipe is cleared.
- Arbitration:
  - Search req_valid starting at pointer ptr, wrapping modulo NUM_REQ.
  - The first set bit i gets req_ready[i]=1; all other bits are 0.
  - No request pending: req_ready=0.
  - req_ready is never high while rst=1.
- Handshake:
  - Transfer happens when req_valid[i] & req_ready[i].
  - A requester must hold req_valid and its operands stable until the transfer.
  - req_valid may drop only after the transfer.
- Pointer update: on a transfer from i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
- Issue timing: a transfer in cycle T gives mul_a/mul_b = operands and mul_in_valid=1 during cycle T+1. mul_in_valid=0 in cycles with no transfer.
- Tag pipe:
  - MUL_LATENCY+1 stages, each {valid, id}.
  - Stage 0 loads {transfer, i} at the same edge as mul_in_valid.
  - Shifts every cycle, with no stall.
- Response:
  - When the last tag stage is valid and carries id k, the next edge sets resp_valid = (1<<k) and resp_data = mul_result.
  - Otherwise resp_valid=0 and resp_data holds its last value.
  - Total latency is transfer in cycle T -> resp_valid in cycle T+2+MUL_LATENCY.
- Throughput:
  - Back-to-back transfers every cycle are supported.
  - Responses return in issue order.
  - No response backpressure: requesters must accept pulses.
- Simultaneous requests: all NUM_REQ held high gives grants rotating 0,1,2,3,0,... with one per cycle.
- Single requester held high: granted every cycle.
- Reset mid-operation: all in-flight operations are dropped and no resp_valid is generated for them. Multiplier outputs arriving after reset are ignored.

Optional Feature:
- Macro: FPMUL_ARB_CHECK_EN.
- Defined:
  - Each cycle after a blanking window of MUL_LATENCY+1 cycles following reset deassertion, compare mul_valid with last-tag-stage valid.
  - Any mismatch sets err=1 at the next edge.
  - err stays 1 until rst.
- Undefined:
  - No comparison logic is built and err is tied 0.
  - mul_valid is unused; responses rely only on the tag pipe.

Test Plan:
- Single request, MUL_LATENCY=4, behavioural multiplier:
  - Stimulus: req 0 with a=0x3F800000, b=0x3F800000.
  - Response: mul_in_valid at T+1; resp_valid=4'b0001, resp_data=0x3F800000 at T+6.
- Four requesters asserted together:
  - Stimulus: operands (2.0,2.0)=0x40000000, (3.0,3.0)=0x40400000, (2.5,2.5)=0x40200000, (-10,-10)=0xC1200000.
  - Response: grants 0,1,2,3 on consecutive cycles.
  - Responses 0x40800000, 0x41100000, 0x40C80000, 0x42C80000 on consecutive cycles, each with the matching one-hot resp_valid.
- Fairness:
  - Stimulus: req 1 and req 3 held high for 8 cycles.
  - Response: grants alternate 1,3,1,3...; each receives 4 responses.
- Pointer wrap:
  - Stimulus: grant to req 3, then req 0 and req 2 request.
  - Response: req 0 granted first.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle 2 cycles after issuing 3 ops.
  - Response: no resp_valid for those ops; err=0; the next request completes normally.
- With FPMUL_ARB_CHECK_EN:
  - Stimulus: multiplier model delays mul_valid by one extra cycle.
  - Response: err=1 at the first mismatch; it remains 1 until rst.
